// File: rtl/fingerprint_matcher_if.sv
// Bus between the fingerprint matcher, the histogram read port and the reference loader.
// The slave modport is the matcher's view; the master modport is the environment's view.
interface fingerprint_matcher_if #(
  parameter int unsigned BIN_W = 20,
  parameter int unsigned SAD_W = 26
) ();
  logic             start;
  logic [5:0]       bin_idx;
  logic [BIN_W-1:0] bin_data;
  logic             ref_wr_en;
  logic [1:0]       ref_wr_sel;
  logic [5:0]       ref_wr_idx;
  logic [BIN_W-1:0] ref_wr_data;
  logic             busy;
  logic             done;
  logic [1:0]       match_id;
  logic             match_valid;
  logic [SAD_W-1:0] best_sad;

  modport slave (
    input  start, bin_data, ref_wr_en, ref_wr_sel, ref_wr_idx, ref_wr_data,
    output bin_idx, busy, done, match_id, match_valid, best_sad
  );

  modport master (
    output start, bin_data, ref_wr_en, ref_wr_sel, ref_wr_idx, ref_wr_data,
    input  bin_idx, busy, done, match_id, match_valid, best_sad
  );
endinterface

// File: rtl/fingerprint_matcher.sv
// Streams a histogram against NUM_REFS stored reference fingerprints, accumulating
// per-reference SAD, and reports the closest reference and whether it is within threshold.
module fingerprint_matcher #(
  parameter int unsigned      NUM_BINS     = 50,
  parameter int unsigned      BIN_W        = 20,
  parameter int unsigned      NUM_REFS     = 4,
  parameter int unsigned      SAD_W        = 26,
  parameter logic [SAD_W-1:0] MATCH_THRESH = SAD_W'(5000)
) (
  input logic                  clk,
  input logic                  rst,
  fingerprint_matcher_if.slave bus
);
  localparam int unsigned IDX_W = 6;
  localparam int unsigned ID_W  = 2;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, COMPARE, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_bin_idx;
  logic [IDX_W-1:0] w_bin_idx_nxt;
  logic             w_clr_acc;
  logic [IDX_W-1:0] r_acc_idx;
  logic             r_acc_vld;
  logic             r_busy;
  logic             r_done;
  logic [ID_W-1:0]  r_match_id;
  logic             r_match_valid;
  logic [SAD_W-1:0] r_best_sad;
  logic [ID_W-1:0]  w_min_id;
  logic [SAD_W-1:0] w_min_sad;

  logic [BIN_W-1:0] r_ref_mem [NUM_REFS][NUM_BINS];
  logic [SAD_W-1:0] r_acc     [NUM_REFS];
  logic [BIN_W-1:0] w_ref_val [NUM_REFS];
  logic [SAD_W-1:0] w_diff    [NUM_REFS];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bin_idx_nxt = '0;
    w_clr_acc     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = FETCH;
          w_clr_acc   = 1'b1;
        end
      end
      FETCH: begin
        if (r_bin_idx == IDX_W'(NUM_BINS - 1)) w_state_nxt = DRAIN;
        else                                   w_bin_idx_nxt = r_bin_idx + IDX_W'(1);
      end
      DRAIN:   w_state_nxt = COMPARE;
      COMPARE: w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // bin_data arrives one cycle after its address, so the ref lookup uses the delayed index
  always_comb begin
    for (int unsigned r = 0; r < NUM_REFS; r++) begin
      w_ref_val[r] = r_ref_mem[r][r_acc_idx];
      w_diff[r]    = (bus.bin_data >= w_ref_val[r]) ? SAD_W'(bus.bin_data - w_ref_val[r])
                                                    : SAD_W'(w_ref_val[r] - bus.bin_data);
    end
  end

  // Strict less-than keeps the lowest index on ties
  always_comb begin
    w_min_sad = r_acc[0];
    w_min_id  = '0;
    for (int unsigned r = 1; r < NUM_REFS; r++) begin
      if (r_acc[r] < w_min_sad) begin
        w_min_sad = r_acc[r];
        w_min_id  = ID_W'(r);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin_idx     <= '0;
      r_acc_idx     <= '0;
      r_acc_vld     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_match_id    <= '0;
      r_match_valid <= 1'b0;
      r_best_sad    <= '0;
      for (int unsigned r = 0; r < NUM_REFS; r++) r_acc[r] <= '0;
    end else begin
      r_bin_idx <= w_bin_idx_nxt;
      r_acc_idx <= r_bin_idx;
      r_acc_vld <= (r_state == FETCH);
      r_busy    <= (w_state_nxt == FETCH) || (w_state_nxt == DRAIN) || (w_state_nxt == COMPARE);
      r_done    <= (w_state_nxt == DONE);
      for (int unsigned r = 0; r < NUM_REFS; r++) begin
        if (w_clr_acc)      r_acc[r] <= '0;
        else if (r_acc_vld) r_acc[r] <= r_acc[r] + w_diff[r];
      end
      if (r_state == COMPARE) begin
        r_match_id    <= w_min_id;
        r_best_sad    <= w_min_sad;
        r_match_valid <= (w_min_sad <= MATCH_THRESH);
      end
    end
  end

  // Reference RAM survives reset; reset still blocks a coincident write
  always_ff @(posedge clk) begin
    if (!rst && (r_state == IDLE) && bus.ref_wr_en && (32'(bus.ref_wr_idx) < NUM_BINS))
      r_ref_mem[bus.ref_wr_sel][bus.ref_wr_idx] <= bus.ref_wr_data;
  end

  assign bus.bin_idx     = r_bin_idx;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.match_id    = r_match_id;
  assign bus.match_valid = r_match_valid;
  assign bus.best_sad    = r_best_sad;
endmodule

// File: tb/tb_fingerprint_matcher.sv
// Directed bench for fingerprint_matcher with a 1-cycle-latency histogram memory model.
module tb_fingerprint_matcher;
  logic clk;
  logic rst;
  logic [19:0] hist [64];
  int n_cmp;
  int n_err;
  int d_edge;
  int d_cnt;

  fingerprint_matcher_if #(.BIN_W(20), .SAD_W(26)) bif ();

  fingerprint_matcher dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bif.bin_data <= hist[bif.bin_idx];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr_ref(input int sel, input int idx, input logic [19:0] d);
    @(negedge clk);
    bif.ref_wr_en   = 1'b1;
    bif.ref_wr_sel  = 2'(sel);
    bif.ref_wr_idx  = 6'(idx);
    bif.ref_wr_data = d;
    @(posedge clk);
    #1 bif.ref_wr_en = 1'b0;
  endtask

  // Edge 0 accepts start; counts done pulses over the following 120 edges
  task automatic run_pass(input bit inj, input int rst_at, output int done_edge, output int done_cnt);
    done_edge = -1;
    done_cnt  = 0;
    @(negedge clk);
    bif.start = 1'b1;
    @(posedge clk);
    #1 bif.start = 1'b0;
    for (int e = 1; e <= 120; e++) begin
      @(negedge clk);
      bif.start       = inj && (e == 10 || e == 30);
      bif.ref_wr_en   = inj && (e == 20);
      bif.ref_wr_sel  = 2'd1;
      bif.ref_wr_idx  = 6'd5;
      bif.ref_wr_data = 20'd0;
      rst             = (e == rst_at);
      @(posedge clk);
      #1;
      if (e == 10) begin
        chk("bin_idx_mid", 64'(bif.bin_idx), 64'd10);
        chk("busy_mid", 64'(bif.busy), 64'd1);
      end
      if (bif.done) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = e;
          chk("busy_at_done", 64'(bif.busy), 64'd0);
        end
      end
    end
    @(negedge clk);
    bif.start     = 1'b0;
    bif.ref_wr_en = 1'b0;
    rst           = 1'b0;
  endtask

  task automatic check_pass(input string tag, input int exp_id, input int exp_sad, input bit exp_valid);
    run_pass(1'b0, -1, d_edge, d_cnt);
    chk({tag, "_latency"}, 64'(d_edge), 64'd52);
    chk({tag, "_done_cnt"}, 64'(d_cnt), 64'd1);
    chk({tag, "_match_id"}, 64'(bif.match_id), 64'(exp_id));
    chk({tag, "_best_sad"}, 64'(bif.best_sad), 64'(exp_sad));
    chk({tag, "_valid"}, 64'(bif.match_valid), 64'(exp_valid));
  endtask

  initial begin
    n_cmp           = 0;
    n_err           = 0;
    clk             = 1'b0;
    rst             = 1'b1;
    bif.start       = 1'b0;
    bif.ref_wr_en   = 1'b0;
    bif.ref_wr_sel  = 2'd0;
    bif.ref_wr_idx  = 6'd0;
    bif.ref_wr_data = 20'd0;
    for (int k = 0; k < 64; k++) hist[k] = 20'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bif.busy), 64'd0);
    chk("rst_done", 64'(bif.done), 64'd0);
    chk("rst_bin_idx", 64'(bif.bin_idx), 64'd0);
    chk("rst_match_id", 64'(bif.match_id), 64'd0);
    chk("rst_valid", 64'(bif.match_valid), 64'd0);
    chk("rst_best_sad", 64'(bif.best_sad), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Exact match with ref1
    for (int k = 0; k < 50; k++) begin
      hist[k] = 20'd100;
      wr_ref(0, k, 20'd0);
      wr_ref(1, k, 20'd100);
      wr_ref(2, k, 20'd200);
      wr_ref(3, k, 20'd300);
    end
    check_pass("exact", 1, 0, 1'b1);

    // Tie between ref1 and ref2 resolves to ref1
    for (int k = 0; k < 50; k++) wr_ref(2, k, 20'd100);
    check_pass("tie", 1, 0, 1'b1);

    // Full-scale histogram against zero refs
    for (int k = 0; k < 50; k++) begin
      hist[k] = 20'hFFFFF;
      for (int r = 0; r < 4; r++) wr_ref(r, k, 20'd0);
    end
    check_pass("fullscale", 0, 52428750, 1'b0);

    // Threshold boundary: 5000 accepted, 5001 rejected
    for (int k = 0; k < 50; k++) begin
      hist[k] = 20'd100;
      for (int r = 1; r < 4; r++) wr_ref(r, k, 20'd1000);
    end
    check_pass("thresh_eq", 0, 5000, 1'b1);
    hist[7] = 20'd101;
    check_pass("thresh_over", 0, 5001, 1'b0);

    // Mixed pattern exercising both subtraction directions
    for (int k = 0; k < 50; k++) begin
      hist[k] = 20'(k);
      wr_ref(0, k, 20'(49 - k));
      wr_ref(1, k, 20'(k + 2));
      wr_ref(2, k, (k >= 25) ? 20'(k) : 20'd0);
      wr_ref(3, k, 20'd0);
    end
    check_pass("mixed", 1, 100, 1'b1);

    // Start and ref writes during a pass are dropped
    run_pass(1'b1, -1, d_edge, d_cnt);
    chk("inj_latency", 64'(d_edge), 64'd52);
    chk("inj_done_cnt", 64'(d_cnt), 64'd1);
    chk("inj_best_sad", 64'(bif.best_sad), 64'd100);
    chk("inj_match_id", 64'(bif.match_id), 64'd1);
    check_pass("after_inj", 1, 100, 1'b1);

    // Reset mid-pass aborts and clears outputs
    run_pass(1'b0, 25, d_edge, d_cnt);
    chk("abort_done_cnt", 64'(d_cnt), 64'd0);
    chk("abort_busy", 64'(bif.busy), 64'd0);
    chk("abort_bin_idx", 64'(bif.bin_idx), 64'd0);
    chk("abort_match_id", 64'(bif.match_id), 64'd0);
    chk("abort_best_sad", 64'(bif.best_sad), 64'd0);
    chk("abort_valid", 64'(bif.match_valid), 64'd0);

    // Reset wins over a same-cycle ref write
    @(negedge clk);
    rst             = 1'b1;
    bif.ref_wr_en   = 1'b1;
    bif.ref_wr_sel  = 2'd1;
    bif.ref_wr_idx  = 6'd5;
    bif.ref_wr_data = 20'd0;
    @(negedge clk);
    rst           = 1'b0;
    bif.ref_wr_en = 1'b0;
    check_pass("restart", 1, 100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fingerprint_matcher.md
FINGERPRINT_MATCHER -- requirements
Module: fingerprint_matcher

Interface
REQ-001 Parameter NUM_BINS, default 50, number of histogram bins per fingerprint.
REQ-002 Parameter BIN_W, default 20, width of one histogram bin count.
REQ-003 Parameter NUM_REFS, default 4, number of stored reference fingerprints.
REQ-004 Parameter SAD_W, default 26, width of sum-of-absolute-difference accumulators; SHALL satisfy 2^SAD_W > NUM_BINS*(2^BIN_W-1).
REQ-005 Parameter MATCH_THRESH, default 26'd5000, maximum best SAD accepted as a match.
REQ-006 clk  input  1  the single clock; all logic on posedge clk.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  request one match pass; typically driven by the histogram stage's stored_data.
REQ-009 bin_idx  output  6  histogram bin read address.
REQ-010 bin_data  input  BIN_W  histogram count for the bin_idx value of the previous cycle (1-cycle read latency).
REQ-011 ref_wr_en  input  1  reference RAM write strobe.
REQ-012 ref_wr_sel  input  2  reference number written.
REQ-013 ref_wr_idx  input  6  bin index written.
REQ-014 ref_wr_data  input  BIN_W  reference bin count written.
REQ-015 busy  output  1  high from start acceptance until done.
REQ-016 done  output  1  one-cycle pulse, result valid.
REQ-017 match_id  output  2  index of the reference with minimum SAD.
REQ-018 match_valid  output  1  best SAD <= MATCH_THRESH.
REQ-019 best_sad  output  SAD_W  minimum SAD of the last pass.

Function
REQ-020 States SHALL be IDLE, FETCH, DRAIN, COMPARE, DONE.
REQ-021 IDLE: start=1 at a clock edge SHALL clear all NUM_REFS accumulators, set bin_idx=0, assert busy, and enter FETCH.
REQ-022 FETCH: bin_idx SHALL increment by 1 per cycle from 0 to NUM_BINS-1; after NUM_BINS-1 is driven, the next state SHALL be DRAIN.
REQ-023 Each cycle after a bin_idx k is driven, every accumulator r SHALL add |bin_data - ref[r][k]|; the subtraction SHALL be unsigned with magnitude by operand compare, with no wrap.
REQ-024 DRAIN: one cycle SHALL accumulate the final bin (NUM_BINS-1), then the FSM SHALL enter COMPARE.
REQ-025 COMPARE: one cycle SHALL select the minimum accumulator; ties SHALL resolve to the lowest reference index. match_id, best_sad and match_valid SHALL register here.
REQ-026 DONE: done=1 for exactly one cycle, busy=0 from this cycle, and the next state SHALL be IDLE.
REQ-027 Latency: with start accepted at edge 0, done SHALL be high in the cycle following edge NUM_BINS+2 (52 for defaults).
REQ-028 start while not IDLE SHALL be ignored; it SHALL NOT be queued.
REQ-029 ref_wr_en while busy=1 SHALL be ignored; in IDLE it SHALL write ref[ref_wr_sel][ref_wr_idx] at the edge.
REQ-030 ref_wr_idx >= NUM_BINS SHALL be ignored.
REQ-031 match_id, match_valid and best_sad SHALL hold their values until the next COMPARE.
REQ-032 bin_idx SHALL be 0 in IDLE.

Reset
REQ-033 rst=1 SHALL force IDLE, busy=0, done=0, bin_idx=0, match_id=0, match_valid=0, best_sad=0, and clear accumulators.
REQ-034 rst asserted mid-pass SHALL abort the pass with no done pulse; the following pass SHALL start clean.
REQ-035 Reference RAM contents SHALL NOT be cleared by rst.
REQ-036 rst SHALL take priority over start and ref_wr_en in the same cycle.

Verification
REQ-037 Load ref0 all bins 0, ref1 all bins 100; histogram model all bins 100; start -> done at cycle 52, match_id=1, best_sad=0, match_valid=1.
REQ-038 Set ref2 equal to ref1; same histogram -> match_id=1 (tie to lowest index).
REQ-039 Histogram all bins 2^20-1, all refs 0 -> best_sad=50*(2^20-1)=52428750, no overflow, match_valid=0.
REQ-040 Pulse start at cycles 10 and 30 of a pass, and ref_wr_en at cycle 20 -> both ignored: one done only, ref unchanged, result unchanged.
REQ-041 Assert rst at cycle 25 of a pass -> no done, outputs 0; restart -> correct result at cycle 52.
REQ-042 Histogram differs from ref0 by 100 in each of 50 bins -> best_sad=5000, match_valid=1; by 101 in one bin (5001) -> match_valid=0.
